// File: rtl/als_sap1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : als_sap1_pkg
// Brief    : Shared constants, converter state type and BCD helper for SAP-1 display.
// Revision : 1.0
// ============================================================================
package als_sap1_pkg;

  localparam int N_DIGITS = 4;

  // Active-low segment patterns, bit order g,f,e,d,c,b,a
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  // One double-dabble iteration on {hundreds, tens, units, binary}
  function automatic logic [19:0] dabble_step(input logic [19:0] v);
    logic [19:0] t;
    t        = v;
    t[19:16] = add3_if_ge5(v[19:16]);
    t[15:12] = add3_if_ge5(v[15:12]);
    t[11:8]  = add3_if_ge5(v[11:8]);
    return {t[18:0], 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/als_dec_7seg.sv
`default_nettype none
// ============================================================================
// Module   : als_dec_7seg
// Brief    : BCD digit to active-low 7-segment pattern with blank override.
// Revision : 1.0
// ============================================================================
module als_dec_7seg
  import als_sap1_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/als_display_saida.sv
`default_nettype none
// ============================================================================
// Module   : als_display_saida
// Brief    : SAP-1 output value to BCD, shown on a 4-digit multiplexed display.
// Revision : 1.0
// ============================================================================
module als_display_saida
  import als_sap1_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dado,
  input  logic       n_load,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       busy
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  conv_state_e       state_q, state_d;
  logic [2:0]        iter_q, iter_d;
  logic [19:0]       sr_q, sr_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_val_q, pend_val_d;
  logic [3:0]        hund_q, hund_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        units_q, units_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [3:0]        digit_sel;
  logic              digit_blank;

  // Converter and pending slot
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    sr_d       = sr_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    hund_d     = hund_q;
    tens_d     = tens_q;
    units_d    = units_q;

    if (state_q != IDLE && !n_load) begin
      pend_d     = 1'b1;
      pend_val_d = dado;
    end

    case (state_q)
      IDLE: begin
        if (!n_load) begin
          state_d = CONV;
          sr_d    = {12'd0, dado};
          iter_d  = 3'd0;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          state_d = CONV;
          sr_d    = {12'd0, pend_val_q};
          iter_d  = 3'd0;
          pend_d  = 1'b0;
        end
      end
      CONV: begin
        sr_d   = dabble_step(sr_q);
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hund_d  = sr_q[19:16];
        tens_d  = sr_q[15:12];
        units_d = sr_q[11:8];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan runs freely; outputs are registered against the next digit index
  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    idx_d     = idx_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      idx_d     = idx_q + IDX_W'(1);
    end

    digit_sel   = 4'd0;
    digit_blank = 1'b1;
    case (idx_d)
      2'd0: begin
        digit_sel   = units_q;
        digit_blank = 1'b0;
      end
      2'd1: begin
        digit_sel   = tens_q;
        digit_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        digit_sel   = hund_q;
        digit_blank = (hund_q == 4'd0);
      end
      default: begin
        digit_sel   = 4'd0;
        digit_blank = 1'b1;
      end
    endcase

    an_d = ~(N_DIGITS'(1) << idx_d);
  end

  als_dec_7seg u_dec (
    .bcd   (digit_sel),
    .blank (digit_blank),
    .seg   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      iter_q     <= 3'd0;
      sr_q       <= 20'd0;
      pend_q     <= 1'b0;
      pend_val_q <= 8'd0;
      hund_q     <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
      div_cnt_q  <= '0;
      idx_q      <= '0;
      an_q       <= 4'b1110;
      seg_q      <= SEG_0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      sr_q       <= sr_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      hund_q     <= hund_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_als_display_saida.sv
`default_nettype none
// ============================================================================
// Module   : tb_als_display_saida
// Brief    : Self-checking bench for als_display_saida against a value-level model.
// Revision : 1.0
// ============================================================================
module tb_als_display_saida;

  localparam int SCAN_DIV = 4;

  logic       clk;
  logic       rst;
  logic [7:0] dado;
  logic       n_load;
  logic [3:0] an;
  logic [6:0] seg;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] seg_tab [10];

  // Model state: displayed number, conversion countdown, pending slot, scan position
  int disp_val;
  int conv_left;
  int conv_val;
  int pend;
  int pend_val;
  int scan_cnt;
  int scan_idx;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_busy;

  als_display_saida #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .dado   (dado),
    .n_load (n_load),
    .an     (an),
    .seg    (seg),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_digit(input int v, input int i);
    case (i)
      0:       return seg_tab[v % 10];
      1:       return (v < 10)  ? 7'b1111111 : seg_tab[(v / 10) % 10];
      2:       return (v < 100) ? 7'b1111111 : seg_tab[v / 100];
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic nl, input logic [7:0] d);
    int old_val;
    if (r) begin
      disp_val  = 0;
      conv_left = 0;
      pend      = 0;
      scan_cnt  = 0;
      scan_idx  = 0;
      e_seg     = 7'b1000000;
    end else begin
      old_val = disp_val;
      if (scan_cnt == SCAN_DIV - 1) begin
        scan_cnt = 0;
        scan_idx = (scan_idx + 1) % 4;
      end else begin
        scan_cnt++;
      end
      e_seg = exp_digit(old_val, scan_idx);
      if (conv_left == 0) begin
        if (!nl) begin
          conv_val  = d;
          conv_left = 9;
          pend      = 0;
        end else if (pend != 0) begin
          conv_val  = pend_val;
          conv_left = 9;
          pend      = 0;
        end
      end else begin
        if (!nl) begin
          pend_val = d;
          pend     = 1;
        end
        conv_left--;
        if (conv_left == 0) disp_val = conv_val;
      end
    end
    e_an   = 4'hF ^ (4'b0001 << scan_idx);
    e_busy = (conv_left != 0);
  endtask

  task automatic step(input logic r, input logic nl, input logic [7:0] d);
    rst    = r;
    n_load = nl;
    dado   = d;
    @(posedge clk);
    model_edge(r, nl, d);
    #1;
    check("an",   32'(an),   32'(e_an));
    check("seg",  32'(seg),  32'(e_seg));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'($urandom));
  endtask

  task automatic load(input logic [7:0] v);
    step(1'b0, 1'b0, v);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;
    disp_val = 0; conv_left = 0; conv_val = 0; pend = 0; pend_val = 0;
    scan_cnt = 0; scan_idx = 0;
    rst = 1'b1; n_load = 1'b1; dado = 8'd0;

    // Reset then a full scan rotation
    step(1'b1, 1'b1, 8'd0);
    step(1'b1, 1'b1, 8'd0);
    idle(20);

    // 255 shown across three digits
    load(8'hFF);
    idle(28);

    // 7 with blanked upper digits
    load(8'h07);
    idle(28);

    // Back-to-back strobes: 10 shown, 100 overwritten by 42
    load(8'h0A);
    idle(1);
    load(8'h64);
    idle(2);
    load(8'h2A);
    idle(30);

    // Reset in the middle of a conversion, then 1
    load(8'h64);
    idle(3);
    step(1'b1, 1'b1, 8'd0);
    idle(12);
    load(8'h01);
    idle(20);

    // 0 after 255
    load(8'hFF);
    idle(12);
    load(8'h00);
    idle(20);

    // Strobe landing on the DONE cycle gets pended
    load(8'd123);
    idle(8);
    load(8'd9);
    idle(24);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1,
           8'($urandom));
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
